// File: rtl/decodificador_secded_pipe.sv
// Two-stage pipelined SECDED (extended Hamming) decoder with valid/ready handshake.
// Optional saturating error counters are built only when SECDED_CONTADORES_EN is defined.
module decodificador_secded_pipe #(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W+PAR_W:0]   palabra_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       dato_out,
  output logic [1:0]              estado_err,
  output logic [PAR_W-1:0]        pos_error,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        cnt_simple,
  output logic [CNT_W-1:0]        cnt_doble
);

  localparam int N = DATA_W + PAR_W + 1;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_SINGLE = 2'b01;
  localparam logic [1:0] ERR_GLOB   = 2'b10;
  localparam logic [1:0] ERR_DOUBLE = 2'b11;

  function automatic logic [PAR_W-1:0] syndrome(input logic [N-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int k = 1; k < N; k++)
      if (cw[k]) s ^= PAR_W'(k);
    return s;
  endfunction

  // Data bits live at the non-power-of-2 positions; the first one found lands in d0.
  function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] cw);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 1; k < N; k++)
      if ((k & (k - 1)) != 0) d = {cw[k], d[DATA_W-1:1]};
    return d;
  endfunction

  logic             v1, v2, rdy2;
  logic [N-1:0]     cw1;
  logic [PAR_W-1:0] syn1;
  logic             glob1;

  assign rdy2      = !v2 || out_ready;
  assign in_ready  = !v1 || rdy2;
  assign out_valid = v2;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      cw1   <= '0;
      syn1  <= '0;
      glob1 <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        cw1   <= palabra_in;
        syn1  <= syndrome(palabra_in);
        glob1 <= ^palabra_in;
      end
    end
  end

  logic [1:0]        est_c;
  logic [DATA_W-1:0] dato_c;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    est_c  = ERR_NONE;
    dato_c = extract(cw1);
    if (syn1 == '0) begin
      est_c = glob1 ? ERR_GLOB : ERR_NONE;
    end else if (int'(syn1) > N - 1 || !glob1) begin
      est_c = ERR_DOUBLE;
    end else begin
      est_c  = ERR_SINGLE;
      dato_c = extract(cw1 ^ (N'(1) << syn1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2         <= 1'b0;
      dato_out   <= '0;
      estado_err <= ERR_NONE;
      pos_error  <= '0;
    end else if (rdy2) begin
      v2 <= v1;
      if (v1) begin
        dato_out   <= dato_c;
        estado_err <= est_c;
        pos_error  <= syn1;
      end
    end
  end

`ifdef SECDED_CONTADORES_EN
  logic xfer;
  assign xfer = v2 && out_ready;

  // Clear has priority over a simultaneous increment; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_simple <= '0;
      cnt_doble  <= '0;
    end else if (cnt_clr) begin
      cnt_simple <= '0;
      cnt_doble  <= '0;
    end else if (xfer) begin
      if ((estado_err == ERR_SINGLE || estado_err == ERR_GLOB) && cnt_simple != '1)
        cnt_simple <= cnt_simple + CNT_W'(1);
      if (estado_err == ERR_DOUBLE && cnt_doble != '1)
        cnt_doble <= cnt_doble + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_simple     = '0;
  assign cnt_doble      = '0;
`endif

endmodule

// File: tb/tb_decodificador_secded_pipe.sv
// Directed bench for decodificador_secded_pipe (DATA_W=4, PAR_W=3, CNT_W=2) with a scoreboard
// queue; counter expectations collapse to 0 when SECDED_CONTADORES_EN is not defined.
`timescale 1ns/1ps
module tb_decodificador_secded_pipe;

`ifdef SECDED_CONTADORES_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] palabra_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] dato_out;
  logic [1:0] estado_err;
  logic [2:0] pos_error;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       cnt_clr = 1'b0;
  logic [1:0] cnt_simple, cnt_doble;

  always #5 clk = ~clk;

  decodificador_secded_pipe #(.DATA_W(4), .PAR_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .palabra_in(palabra_in), .in_valid(in_valid), .in_ready(in_ready),
    .dato_out(dato_out), .estado_err(estado_err), .pos_error(pos_error),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
    .cnt_simple(cnt_simple), .cnt_doble(cnt_doble)
  );

  typedef struct {
    logic [7:0] cw;
    logic [3:0] d;
    logic [1:0] e;
    logic [2:0] p;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[7];
  int   n_vec = 0, n_err = 0;
  int   m_simple = 0, m_doble = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [7:0] cw, logic [3:0] d, logic [1:0] e, logic [2:0] p);
    vec_t v;
    v.cw = cw; v.d = d; v.e = e; v.p = p;
    return v;
  endfunction

  function automatic logic [31:0] exp_cnt(int m);
    return CNT_EN ? 32'(m) : 32'd0;
  endfunction

  function automatic int sat_inc(int m);
    return (m == 3) ? 3 : m + 1;
  endfunction

  // Present a codeword until it is accepted; returns on the negedge after the accepting edge.
  task automatic offer(input vec_t v);
    int n;
    palabra_in = v.cw;
    in_valid   = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("accept_timeout", in_ready, 1);
    if (in_ready) exp_q.push_back(v);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk); #3;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Scoreboard: outputs must match the queue head every cycle they are valid, stall or not.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check("cnt_simple", cnt_simple, exp_cnt(m_simple));
      check("cnt_doble", cnt_doble, exp_cnt(m_doble));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          check("dato_out", dato_out, exp_q[0].d);
          check("estado_err", estado_err, exp_q[0].e);
          check("pos_error", pos_error, exp_q[0].p);
          if (out_ready) begin
            if (exp_q[0].e == 2'b01 || exp_q[0].e == 2'b10) m_simple = sat_inc(m_simple);
            if (exp_q[0].e == 2'b11) m_doble = sat_inc(m_doble);
            void'(exp_q.pop_front());
          end
        end
      end
      if (cnt_clr) begin
        m_simple = 0;
        m_doble  = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // AA is the clean codeword for data 1011 (data at positions 3,5,6,7).
    vecs[0] = mk(8'hAA, 4'b1011, 2'b00, 3'd0);
    vecs[1] = mk(8'hEA, 4'b1011, 2'b01, 3'd6);  // data bit 6 flipped
    vecs[2] = mk(8'hAB, 4'b1011, 2'b10, 3'd0);  // global parity bit flipped
    // Positions 3 and 6 are both data bits, so d0 and d2 come out flipped and uncorrected.
    vecs[3] = mk(8'hE2, 4'b1110, 2'b11, 3'd5);
    vecs[4] = mk(8'hA8, 4'b1011, 2'b01, 3'd1);  // Hamming parity bit 1 flipped
    vecs[5] = mk(8'h00, 4'b0000, 2'b00, 3'd0);
    vecs[6] = mk(8'hFF, 4'b1111, 2'b00, 3'd0);

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dato", dato_out, 0);
    check("rst_estado", estado_err, 0);
    check("rst_pos", pos_error, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cnt_simple", cnt_simple, 0);
    check("rst_cnt_doble", cnt_doble, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Latency: nothing out after the accepting edge, result valid after the next one.
    offer(vecs[0]);
    in_valid = 1'b0;
    #1 check("lat_edge1", out_valid, 0);
    @(negedge clk);
    #1 check("lat_edge2", out_valid, 1);
    @(negedge clk);

    for (int i = 1; i < 7; i++) offer(vecs[i]);
    in_valid = 1'b0;
    drain();

    // Backpressure: two words fill the pipe, the third must wait while the head holds still.
    out_ready = 1'b0;
    offer(vecs[5]);
    offer(vecs[6]);
    palabra_in = vecs[0].cw;
    in_valid   = 1'b1;
    #1 check("bp_in_ready_low", in_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    check("bp_held_valid", out_valid, 1);
    check("bp_held_dato", dato_out, 4'b0000);
    check("bp_in_ready_still_low", in_ready, 0);
    @(negedge clk);
    out_ready = 1'b1;
    offer(vecs[0]);
    in_valid = 1'b0;
    drain();

    // Counters: clear, then five single errors saturate the 2-bit count at 3.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) offer(vecs[1]);
    in_valid = 1'b0;
    drain();
    #1 check("cnt_saturated", cnt_simple, CNT_EN ? 32'd3 : 32'd0);

    // A clear coinciding with the sixth word's output transfer wins.
    offer(vecs[1]);
    in_valid = 1'b0;
    #1;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    check("wait_out_valid", out_valid, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1 check("cnt_clr_wins", cnt_simple, 0);
    @(negedge clk);

    // Reset mid-stream discards everything in flight.
    offer(vecs[0]);
    offer(vecs[1]);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_dato", dato_out, 0);
    check("midrst_estado", estado_err, 0);
    check("midrst_pos", pos_error, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    m_simple = 0;
    m_doble  = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #3 check("post_rst_no_stale", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
